// File: rtl/pcie_tx_pkg.sv
// Shared PCIe transmit-path constants: scrambler seed, polynomial taps and
// the K-codes the scrambler reacts to.
package pcie_tx_pkg;

  localparam logic [15:0] SCR_SEED = 16'hFFFF;
  // Galois taps for x^16+x^5+x^4+x^3+1; the x^16 term is the shifted-out MSB
  localparam logic [15:0] SCR_POLY = 16'h0039;
  localparam logic [7:0]  COM_K    = 8'hBC;
  localparam logic [7:0]  SKP_K    = 8'h1C;

  typedef enum logic [1:0] {
    SYM_DATA = 2'd0,
    SYM_COM  = 2'd1,
    SYM_SKP  = 2'd2
  } sym_class_e;

endpackage

// File: rtl/scr_lfsr_step.sv
// One symbol's worth of scrambler LFSR: eight Galois bit-steps plus the
// scramble byte taken from the incoming (pre-advance) state.
module scr_lfsr_step
  import pcie_tx_pkg::*;
#(
  parameter logic [15:0] POLY = SCR_POLY
) (
  input  logic [15:0] lfsr,
  output logic [15:0] lfsr_next,
  output logic [7:0]  scr_byte
);

  // Scramble bit i comes from lfsr[15-i], i.e. the top byte bit-reversed
  always_comb begin
    scr_byte = '0;
    for (int i = 0; i < 8; i++) begin
      scr_byte[i] = lfsr[15-i];
    end
  end

  always_comb begin
    lfsr_next = lfsr;
    for (int i = 0; i < 8; i++) begin
      if (lfsr_next[15]) lfsr_next = {lfsr_next[14:0], 1'b0} ^ POLY;
      else               lfsr_next = {lfsr_next[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/tx_scrambler.sv
// PCIe transmit scrambler: one-entry registered output stage with a 16-bit
// LFSR that reseeds on COM, holds on SKP and advances on every other symbol.
module tx_scrambler
  import pcie_tx_pkg::*;
#(
  parameter logic [15:0] SEED    = SCR_SEED,
  parameter logic [7:0]  COM_SYM = COM_K,
  parameter logic [7:0]  SKP_SYM = SKP_K
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_ts,
  input  logic       scramble_en,
  input  logic       lfsr_reinit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_k
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_adv;
  logic [15:0] lfsr_d;
  logic [7:0]  scr_byte;
  logic [7:0]  sym_d;
  logic        accept;
  sym_class_e  sym_class;

  scr_lfsr_step #(.POLY(SCR_POLY)) u_step (
    .lfsr      (lfsr),
    .lfsr_next (lfsr_adv),
    .scr_byte  (scr_byte)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sym_class = SYM_DATA;
    if (in_k && (in_data == COM_SYM))      sym_class = SYM_COM;
    else if (in_k && (in_data == SKP_SYM)) sym_class = SYM_SKP;
  end

  // A same-cycle reinit still lets the accepted symbol use the old state
  always_comb begin
    lfsr_d = lfsr;
    if (accept) begin
      case (sym_class)
        SYM_COM: lfsr_d = SEED;
        SYM_SKP: lfsr_d = lfsr;
        default: lfsr_d = lfsr_adv;
      endcase
    end
    if (lfsr_reinit) lfsr_d = SEED;
  end

  always_comb begin
    sym_d = in_data;
    if (scramble_en && !in_k && !in_ts) sym_d = in_data ^ scr_byte;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr      <= SEED;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_k     <= 1'b0;
    end else begin
      lfsr <= lfsr_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sym_d;
        out_k     <= in_k;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
